// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared state encoding and checksum helper for the RAM image loader.
package ram_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;
  localparam int CKSUM_W = 8;
  function automatic logic [CKSUM_W-1:0] cksum_add(input logic [CKSUM_W-1:0] sum, input logic [CKSUM_W-1:0] b);
    return sum + b;
  endfunction
endpackage

// File: rtl/ram_image_loader.sv
// ram_image_loader: writes a valid/ready byte stream into consecutive RAM addresses with count/checksum/overflow tracking.
// Optional readback check of the loaded image when LOADER_VERIFY_EN is defined.
module ram_image_loader
  import ram_loader_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  start_addr_i,
  input  logic               dl_valid_i,
  input  logic [DATA_W-1:0]  dl_data_i,
  output logic               dl_ready_o,
  input  logic               dl_end_i,
  output logic               ram_we_o,
  output logic [ADDR_W-1:0]  ram_addr_o,
  output logic [DATA_W-1:0]  ram_data_o,
  input  logic [DATA_W-1:0]  ram_q_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [ADDR_W:0]    count_o,
  output logic [CKSUM_W-1:0] checksum_o,
  output logic               overflow_o,
  output logic               verify_err_o
);
  state_t state;
  logic [ADDR_W-1:0] ptr;
  logic full;
  logic acc;
  assign dl_ready_o = state == LOAD;
  assign busy_o = state == LOAD || state == VERIFY;
  assign done_o = state == DONE;
  assign acc = dl_ready_o && dl_valid_i && !start_i;
`ifdef LOADER_VERIFY_EN
  localparam state_t END_ST = VERIFY;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0] issued;
  logic [CKSUM_W-1:0] sum;
  logic rd_v1, rd_v2;
`else
  localparam state_t END_ST = DONE;
  logic unused_q;
  assign unused_q = ^ram_q_i;
  assign verify_err_o = 1'b0;
`endif
  // full marks that the last RAM word has been written; the pointer never wraps
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      ptr <= '0;
      full <= 1'b0;
      ram_we_o <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      count_o <= '0;
      checksum_o <= '0;
      overflow_o <= 1'b0;
`ifdef LOADER_VERIFY_EN
      base <= '0;
      issued <= '0;
      sum <= '0;
      rd_v1 <= 1'b0;
      rd_v2 <= 1'b0;
      verify_err_o <= 1'b0;
`endif
    end else begin
      ram_we_o <= 1'b0;
      if (start_i) begin
        state <= LOAD;
        ptr <= start_addr_i;
        full <= 1'b0;
        count_o <= '0;
        checksum_o <= '0;
        overflow_o <= 1'b0;
`ifdef LOADER_VERIFY_EN
        base <= start_addr_i;
        issued <= '0;
        sum <= '0;
        rd_v1 <= 1'b0;
        rd_v2 <= 1'b0;
        verify_err_o <= 1'b0;
`endif
      end else if (state == LOAD) begin
        if (acc && full) overflow_o <= 1'b1;
        else if (acc) begin
          ram_we_o <= 1'b1;
          ram_addr_o <= ptr;
          ram_data_o <= dl_data_i;
          count_o <= count_o + 1'b1;
          checksum_o <= cksum_add(checksum_o, CKSUM_W'(dl_data_i));
          full <= &ptr;
          ptr <= (&ptr) ? ptr : ptr + 1'b1;
        end
        if (dl_end_i) state <= END_ST;
      end
`ifdef LOADER_VERIFY_EN
      // read data returns two edges after the address register is loaded
      else if (state == VERIFY) begin
        rd_v1 <= issued != count_o;
        rd_v2 <= rd_v1;
        if (issued != count_o) begin
          ram_addr_o <= base + issued[ADDR_W-1:0];
          issued <= issued + 1'b1;
        end
        if (rd_v2) sum <= cksum_add(sum, CKSUM_W'(ram_q_i));
        if (issued == count_o && !rd_v1 && !rd_v2) begin
          verify_err_o <= sum != checksum_o;
          state <= DONE;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_ram_image_loader.sv
// tb_ram_image_loader: directed self-checking bench for ram_image_loader with a registered-read RAM model.
module tb_ram_image_loader;
  logic clk_i = 1'b0;
  logic rst_n_i, start_i, dl_valid_i, dl_end_i, dl_ready_o, ram_we_o, busy_o, done_o, overflow_o, verify_err_o;
  logic [9:0] start_addr_i, ram_addr_o;
  logic [7:0] dl_data_i, ram_data_o, ram_q_i, checksum_o;
  logic [10:0] count_o;
  logic [10:0] corrupt;
  logic [7:0] mem [0:1023];
  int wr_cnt = 0, w0, checks = 0, failures = 0;
  logic [7:0] basic [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] gap [3] = '{8'h01, 8'h80, 8'hFF};

  ram_image_loader #(.DATA_W(8), .ADDR_W(10)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .start_addr_i(start_addr_i),
    .dl_valid_i(dl_valid_i), .dl_data_i(dl_data_i), .dl_ready_o(dl_ready_o), .dl_end_i(dl_end_i),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_q_i(ram_q_i),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o), .checksum_o(checksum_o),
    .overflow_o(overflow_o), .verify_err_o(verify_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (ram_we_o) begin
      mem[ram_addr_o] <= ({1'b0, ram_addr_o} == corrupt) ? ~ram_data_o : ram_data_o;
      wr_cnt <= wr_cnt + 1;
    end
    ram_q_i <= mem[ram_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic begin_load(input logic [9:0] a);
    start_i = 1'b1;
    start_addr_i = a;
    tick;
    start_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    dl_valid_i = 1'b1;
    dl_data_i = b;
    tick;
    dl_valid_i = 1'b0;
  endtask

  task automatic end_load;
    dl_end_i = 1'b1;
    tick;
    dl_end_i = 1'b0;
    for (int i = 0; i < 40 && !done_o; i++) tick;
    chk("done_wait", done_o, 1);
  endtask

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; start_addr_i = '0; dl_valid_i = 1'b0;
    dl_data_i = '0; dl_end_i = 1'b0; corrupt = 11'h7FF;
    tick; tick;
    chk("rst_we", ram_we_o, 0);
    chk("rst_ready", dl_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_cksum", checksum_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_verr", verify_err_o, 0);
    chk("rst_addr", ram_addr_o, 0);
    rst_n_i = 1'b1;
    tick;
    chk("idle_ready", dl_ready_o, 0);
    // basic back-to-back load
    begin_load(10'h100);
    chk("load_busy", busy_o, 1);
    chk("load_ready", dl_ready_o, 1);
    w0 = wr_cnt;
    for (int i = 0; i < 4; i++) begin
      send(basic[i]);
      chk("basic_we", ram_we_o, 1);
      chk("basic_addr", ram_addr_o, 32'h100 + i);
      chk("basic_data", ram_data_o, basic[i]);
    end
    end_load;
    chk("basic_busy", busy_o, 0);
    chk("basic_ready", dl_ready_o, 0);
    chk("basic_count", count_o, 4);
    chk("basic_cksum", checksum_o, 8'hAA);
    chk("basic_writes", wr_cnt - w0, 4);
    chk("basic_mem0", mem[10'h100], 8'h11);
    chk("basic_mem3", mem[10'h103], 8'h44);
    // gapped stream
    begin_load(10'h200);
    chk("restart_done_clr", done_o, 0);
    for (int i = 0; i < 3; i++) begin
      send(gap[i]);
      chk("gap_we", ram_we_o, 1);
      chk("gap_addr", ram_addr_o, 32'h200 + i);
      chk("gap_data", ram_data_o, gap[i]);
      tick;
      chk("gap_we_idle", ram_we_o, 0);
    end
    end_load;
    chk("gap_count", count_o, 3);
    chk("gap_cksum", checksum_o, 8'h80);
    // overflow at the top of RAM
    begin_load(10'h3FE);
    w0 = wr_cnt;
    send(8'hAA);
    chk("ovf_addr0", ram_addr_o, 10'h3FE);
    send(8'hBB);
    chk("ovf_addr1", ram_addr_o, 10'h3FF);
    chk("ovf_early", overflow_o, 0);
    send(8'hCC);
    chk("ovf_drop_we", ram_we_o, 0);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_ready", dl_ready_o, 1);
    send(8'hDD);
    chk("ovf_drop_we2", ram_we_o, 0);
    chk("ovf_ready2", dl_ready_o, 1);
    end_load;
    chk("ovf_count", count_o, 2);
    chk("ovf_cksum", checksum_o, 8'h65);
    chk("ovf_sticky", overflow_o, 1);
    chk("ovf_writes", wr_cnt - w0, 2);
    chk("ovf_mem", mem[10'h3FF], 8'hBB);
    // byte on the same cycle as dl_end
    begin_load(10'h050);
    chk("start_ovf_clr", overflow_o, 0);
    dl_valid_i = 1'b1; dl_data_i = 8'h5A; dl_end_i = 1'b1;
    tick;
    dl_valid_i = 1'b0; dl_end_i = 1'b0;
    chk("end_we", ram_we_o, 1);
    chk("end_addr", ram_addr_o, 10'h050);
    chk("end_data", ram_data_o, 8'h5A);
    chk("end_ready", dl_ready_o, 0);
`ifndef LOADER_VERIFY_EN
    chk("end_done", done_o, 1);
`endif
    send(8'h77);
    chk("end_no_accept", ram_we_o, 0);
    for (int i = 0; i < 40 && !done_o; i++) tick;
    chk("end_count", count_o, 1);
    chk("end_cksum", checksum_o, 8'h5A);
    // restart mid-load; byte coincident with start is ignored
    begin_load(10'h300);
    send(8'h01);
    send(8'h02);
    start_i = 1'b1; start_addr_i = 10'h020; dl_valid_i = 1'b1; dl_data_i = 8'h99;
    tick;
    start_i = 1'b0; dl_valid_i = 1'b0;
    chk("rs_we", ram_we_o, 0);
    chk("rs_count", count_o, 0);
    chk("rs_cksum", checksum_o, 0);
    send(8'h3C);
    chk("rs_we2", ram_we_o, 1);
    chk("rs_addr", ram_addr_o, 10'h020);
    chk("rs_data", ram_data_o, 8'h3C);
    end_load;
    chk("rs_count2", count_o, 1);
    chk("rs_cksum2", checksum_o, 8'h3C);
    chk("rs_old0", mem[10'h300], 8'h01);
    chk("rs_old1", mem[10'h301], 8'h02);
    chk("rs_new", mem[10'h020], 8'h3C);
`ifdef LOADER_VERIFY_EN
    corrupt = 11'h083;
    begin_load(10'h080);
    for (int i = 1; i <= 8; i++) send(8'(i));
    end_load;
    chk("ver_bad_err", verify_err_o, 1);
    chk("ver_bad_cksum", checksum_o, 8'h24);
    corrupt = 11'h7FF;
    begin_load(10'h080);
    chk("ver_err_clr", verify_err_o, 0);
    for (int i = 1; i <= 8; i++) send(8'(i));
    end_load;
    chk("ver_ok_err", verify_err_o, 0);
    begin_load(10'h010);
    end_load;
    chk("ver_zero_err", verify_err_o, 0);
    chk("ver_zero_count", count_o, 0);
`endif
    // reset while a write is pending
    begin_load(10'h1F0);
    send(8'hEE);
    chk("mr_we", ram_we_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk("mr_we_off", ram_we_o, 0);
    chk("mr_busy", busy_o, 0);
    chk("mr_count", count_o, 0);
    tick;
    chk("mr_we_hold", ram_we_o, 0);
    rst_n_i = 1'b1;
    tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
